// File: rtl/sample_ctrl.sv
// Sample accumulator controller: edge-detected sample intake, 4-state sequencer, batch sum/close.
// Optional macro SAMPLE_CTRL_SAT_EN: accumulator saturates on carry-out instead of wrapping.
module sample_ctrl #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 26
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              data_ready,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              one_k_samples,
  output logic              cnt_up,
  output logic              modwait,
  output logic [ACC_W-1:0]  sum_out,
  output logic              batch_done,
  output logic              err,
  output logic              ovf
);

  typedef enum logic [1:0] {IDLE, LOAD, ADD, COUNT} state_t;

  state_t              state_reg, state_next;
  logic                dr_prev_reg, ok_prev_reg;
  logic                dr_rise, ok_rise;
  logic [DATA_W-1:0]   sample_reg;
  logic [ACC_W-1:0]    acc_reg, acc_next;
  logic [ACC_W:0]      add_full;
  logic [ACC_W-1:0]    add_res;
  logic                carry;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      dr_prev_reg <= 1'b0;
      ok_prev_reg <= 1'b0;
    end else begin
      dr_prev_reg <= data_ready;
      ok_prev_reg <= one_k_samples;
    end
  end

  assign dr_rise = data_ready & ~dr_prev_reg;
  assign ok_rise = one_k_samples & ~ok_prev_reg;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    cnt_up     = 1'b0;
    modwait    = 1'b0;
    case (state_reg)
      IDLE:  if (dr_rise) state_next = LOAD;
      LOAD:  begin modwait = 1'b1; state_next = ADD; end
      ADD:   begin modwait = 1'b1; state_next = COUNT; end
      COUNT: begin modwait = 1'b1; cnt_up = 1'b1; state_next = IDLE; end
      default: state_next = IDLE;
    endcase
  end

  // One extra bit on the adder exposes the carry-out that drives ovf.
  assign add_full = {1'b0, acc_reg} + {{(ACC_W + 1 - DATA_W){1'b0}}, sample_reg};
  assign carry    = add_full[ACC_W];

`ifdef SAMPLE_CTRL_SAT_EN
  assign add_res = carry ? {ACC_W{1'b1}} : add_full[ACC_W-1:0];
`else
  assign add_res = add_full[ACC_W-1:0];
`endif

  assign acc_next = (state_reg == ADD) ? add_res : acc_reg;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sample_reg <= '0;
      acc_reg    <= '0;
      sum_out    <= '0;
      batch_done <= 1'b0;
      err        <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      if (dr_rise && state_reg == IDLE) sample_reg <= sample_data;
      if (dr_rise && state_reg != IDLE) err <= 1'b1;
      // A batch close takes the freshly added value when it lands on the ADD exit.
      if (ok_rise) begin
        sum_out    <= acc_next;
        acc_reg    <= '0;
        ovf        <= 1'b0;
        batch_done <= 1'b1;
      end else begin
        acc_reg    <= acc_next;
        batch_done <= 1'b0;
        if (state_reg == ADD && carry) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sample_ctrl.sv
// Self-checking bench for sample_ctrl: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_sample_ctrl;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 26;
  localparam longint ACC_MAX = (longint'(1) << ACC_W) - 1;

  logic              clk = 1'b0;
  logic              n_reset = 1'b1;
  logic              data_ready = 1'b0;
  logic [DATA_W-1:0] sample_data = '0;
  logic              one_k_samples = 1'b0;
  logic              cnt_up, modwait, batch_done, err, ovf;
  logic [ACC_W-1:0]  sum_out;

  int tests = 0;
  int fails = 0;

  sample_ctrl #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .n_reset(n_reset), .data_ready(data_ready), .sample_data(sample_data),
    .one_k_samples(one_k_samples), .cnt_up(cnt_up), .modwait(modwait), .sum_out(sum_out),
    .batch_done(batch_done), .err(err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: a sample occupies the unit for 3 cycles after acceptance;
  // it is summed as the 2nd busy cycle ends and counted in the 3rd.
  longint m_acc, m_pend, m_sum, m_s;
  int     m_busy;
  bit     m_err, m_ovf, m_bd, m_dr_prev, m_ok_prev, m_dr_rise, m_ok_rise;

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      m_acc = 0; m_pend = 0; m_sum = 0; m_busy = 0;
      m_err = 0; m_ovf = 0; m_bd = 0; m_dr_prev = 0; m_ok_prev = 0;
    end else begin
      m_dr_rise = data_ready && !m_dr_prev;
      m_ok_rise = one_k_samples && !m_ok_prev;
      m_dr_prev = data_ready;
      m_ok_prev = one_k_samples;
      if (m_busy == 2) begin
        m_s = m_acc + m_pend;
        if (m_s > ACC_MAX) begin
          m_ovf = 1;
`ifdef SAMPLE_CTRL_SAT_EN
          m_acc = ACC_MAX;
`else
          m_acc = m_s % (ACC_MAX + 1);
`endif
        end else m_acc = m_s;
      end
      m_bd = 0;
      if (m_ok_rise) begin
        m_sum = m_acc; m_acc = 0; m_ovf = 0; m_bd = 1;
      end
      if (m_dr_rise && m_busy == 0) begin
        m_pend = longint'(sample_data);
        m_busy = 3;
      end else begin
        if (m_dr_rise) m_err = 1;
        if (m_busy > 0) m_busy--;
      end
    end
  end

  int mw_cnt = 0, cu_cnt = 0, bd_cnt = 0, mw_at_cu = 0;

  always @(negedge clk) begin
    chk("cyc modwait",    64'(modwait),    64'(m_busy != 0));
    chk("cyc cnt_up",     64'(cnt_up),     64'(m_busy == 1));
    chk("cyc batch_done", 64'(batch_done), 64'(m_bd));
    chk("cyc sum_out",    64'(sum_out),    64'(m_sum));
    chk("cyc err",        64'(err),        64'(m_err));
    chk("cyc ovf",        64'(ovf),        64'(m_ovf));
    if (modwait) mw_cnt++;
    if (cnt_up) begin cu_cnt++; mw_at_cu = mw_cnt; end
    if (batch_done) bd_cnt++;
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic clr();
    mw_cnt = 0; cu_cnt = 0; bd_cnt = 0; mw_at_cu = 0;
  endtask

  task automatic send(input logic [DATA_W-1:0] s);
    data_ready = 1'b1; sample_data = s;
    step();
    data_ready = 1'b0;
    idle(3);
  endtask

  task automatic close_batch(input int hold);
    one_k_samples = 1'b1;
    idle(hold);
    one_k_samples = 1'b0;
    idle(2);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " cnt_up"},     64'(cnt_up),     64'd0);
    chk({tag, " modwait"},    64'(modwait),    64'd0);
    chk({tag, " sum_out"},    64'(sum_out),    64'd0);
    chk({tag, " batch_done"}, 64'(batch_done), 64'd0);
    chk({tag, " err"},        64'(err),        64'd0);
    chk({tag, " ovf"},        64'(ovf),        64'd0);
  endtask

  initial begin
    #1 n_reset = 1'b0;
    idle(3);
    chk_all_zero("reset");
    n_reset = 1'b1;

    // Single sample: 3 busy cycles, count strobe in the 3rd.
    clr();
    send(16'h0010);
    idle(1);
    chk("single mw_cycles", 64'(mw_cnt), 64'd3);
    chk("single cnt_up_cnt", 64'(cu_cnt), 64'd1);
    chk("single cnt_up_pos", 64'(mw_at_cu), 64'd3);
    clr();
    close_batch(1);
    chk("single sum", 64'(sum_out), 64'h10);
    chk("single bd_cnt", 64'(bd_cnt), 64'd1);

    // 1000 full-scale samples, batch close held 5 cycles.
    repeat (1000) send(16'hFFFF);
    chk("k1000 ovf", 64'(ovf), 64'd0);
    clr();
    close_batch(5);
    chk("k1000 sum", 64'(sum_out), 64'd65535000);
    chk("k1000 bd_cnt", 64'(bd_cnt), 64'd1);
    close_batch(1);
    chk("k1000 acc_cleared", 64'(sum_out), 64'd0);

    // Batch close coincident with the ADD exit.
    send(16'h000A);
    data_ready = 1'b1; sample_data = 16'h0005;
    step();
    data_ready = 1'b0;
    step();
    one_k_samples = 1'b1;
    step();
    one_k_samples = 1'b0;
    idle(2);
    chk("coinc sum", 64'(sum_out), 64'h0F);
    close_batch(1);
    chk("coinc acc_cleared", 64'(sum_out), 64'd0);

    // Overrun: second rise while in ADD is dropped and flagged.
    clr();
    data_ready = 1'b1; sample_data = 16'h0003;
    step();
    data_ready = 1'b0;
    step();
    data_ready = 1'b1; sample_data = 16'h0007;
    step();
    data_ready = 1'b0;
    idle(3);
    chk("overrun err", 64'(err), 64'd1);
    chk("overrun cnt_up_cnt", 64'(cu_cnt), 64'd1);
    close_batch(1);
    chk("overrun sum", 64'(sum_out), 64'h3);
    send(16'h0002);
    chk("overrun err_sticky", 64'(err), 64'd1);
    close_batch(1);
    chk("overrun next_sum", 64'(sum_out), 64'h2);

    // Accumulator overflow: 1100 full-scale samples.
    repeat (1100) send(16'hFFFF);
    chk("ovf1100 ovf", 64'(ovf), 64'd1);
    close_batch(1);
`ifdef SAMPLE_CTRL_SAT_EN
    chk("ovf1100 sum", 64'(sum_out), 64'h3FFFFFF);
`else
    chk("ovf1100 sum", 64'(sum_out), 64'd4979636);
`endif
    chk("ovf1100 ovf_cleared", 64'(ovf), 64'd0);

    // Reset while in LOAD.
    clr();
    data_ready = 1'b1; sample_data = 16'h0055;
    step();
    n_reset = 1'b0; data_ready = 1'b0;
    #1;
    chk_all_zero("midrst");
    idle(2);
    n_reset = 1'b1;
    idle(4);
    chk("midrst cnt_up_cnt", 64'(cu_cnt), 64'd0);
    send(16'h0021);
    idle(1);
    chk("midrst next_cnt_up", 64'(cu_cnt), 64'd1);
    close_batch(1);
    chk("midrst next_sum", 64'(sum_out), 64'h21);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
